// File: rtl/tri_pkg.sv
// Shared definitions for the triangle hit sequencer: default coordinate
// width, area-width derivation and the sequencer state encoding.
package tri_pkg;

  localparam int COORD_W_DEF = 10;

  // Signed double area of three unsigned COORD_W points needs 2*COORD_W+3
  // bits: each product stays below 2^(2*COORD_W), three of them sum below
  // 2^(2*COORD_W+2), plus one sign bit.
  function automatic int area_w(input int coord_w);
    return 2 * coord_w + 3;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/tri_area2.sv
// Combinational signed double area of triangle (A,B,C):
//   ax*(by-cy) + bx*(cy-ay) + cx*(ay-by)
// All arithmetic is done at AREA_W signed bits, which holds every possible
// result exactly, so the truncation of the expression never loses bits.
module tri_area2
  import tri_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int AREA_W  = area_w(COORD_W)
) (
  input  logic        [COORD_W-1:0] ax,
  input  logic        [COORD_W-1:0] ay,
  input  logic        [COORD_W-1:0] bx,
  input  logic        [COORD_W-1:0] by,
  input  logic        [COORD_W-1:0] cx,
  input  logic        [COORD_W-1:0] cy,
  output logic signed [AREA_W-1:0]  area
);

  localparam int PAD = AREA_W - COORD_W;

  logic signed [AREA_W-1:0] sax, say, sbx, sby, scx, scy;

  assign sax = $signed({{PAD{1'b0}}, ax});
  assign say = $signed({{PAD{1'b0}}, ay});
  assign sbx = $signed({{PAD{1'b0}}, bx});
  assign sby = $signed({{PAD{1'b0}}, by});
  assign scx = $signed({{PAD{1'b0}}, cx});
  assign scy = $signed({{PAD{1'b0}}, cy});

  assign area = sax * (sby - scy) + sbx * (scy - say) + scx * (say - sby);

endmodule

// File: rtl/tri_hit_seq.sv
// Point-in-triangle sequencer. Up to NTRI triangles are stored; a query
// point is tested against each one in turn using one shared area unit over
// four clocks per triangle. The point is inside or on triangle ABC exactly
// when |ABC| == |PBC| + |APC| + |ABP|.
// Optional build macro TRI_HIT_DEGEN_REJECT_EN: when defined, triangles of
// zero area never report a hit.
module tri_hit_seq
  import tri_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int NTRI    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tri_we,
  input  logic [3:0]         tri_idx,
  input  logic [COORD_W-1:0] tri_ax,
  input  logic [COORD_W-1:0] tri_ay,
  input  logic [COORD_W-1:0] tri_bx,
  input  logic [COORD_W-1:0] tri_by,
  input  logic [COORD_W-1:0] tri_cx,
  input  logic [COORD_W-1:0] tri_cy,
  input  logic               q_valid,
  output logic               q_ready,
  input  logic [COORD_W-1:0] q_px,
  input  logic [COORD_W-1:0] q_py,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [NTRI-1:0]    hit_mask,
  output logic               hit_any
);

  localparam int AREA_W = area_w(COORD_W);
  localparam int SUM_W  = AREA_W + 2;

  typedef struct packed {
    logic [COORD_W-1:0] ax;
    logic [COORD_W-1:0] ay;
    logic [COORD_W-1:0] bx;
    logic [COORD_W-1:0] by;
    logic [COORD_W-1:0] cx;
    logic [COORD_W-1:0] cy;
  } vtx_t;

  state_t             state;
  logic [1:0]         phase;
  logic [3:0]         tri_cnt;
  logic [COORD_W-1:0] px;
  logic [COORD_W-1:0] py;
  logic [AREA_W-1:0]  a0_mag;
  logic [SUM_W-1:0]   sum;

  // Read view of the triangle store; slots beyond NTRI read as zero and
  // are never selected because tri_cnt stops at NTRI-1.
  vtx_t               slot_rd [16];
  logic [NTRI-1:0]    tri_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_slot
      if (gi < NTRI) begin : g_used
        vtx_t slot;
        // Store one triangle; writes are accepted only while idle, so the
        // triangle under evaluation never changes mid-query.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            slot <= '0;
          end else if (tri_we && state == IDLE && tri_idx == 4'(gi)) begin
            slot <= {tri_ax, tri_ay, tri_bx, tri_by, tri_cx, tri_cy};
          end
        end
        assign slot_rd[gi] = slot;
      end else begin : g_unused
        assign slot_rd[gi] = '0;
      end
    end

    for (gi = 0; gi < NTRI; gi++) begin : g_sel
      assign tri_sel[gi] = (tri_cnt == 4'(gi));
    end
  endgenerate

  vtx_t               cur;
  logic [COORD_W-1:0] u_ax, u_ay, u_bx, u_by, u_cx, u_cy;
  logic signed [AREA_W-1:0] area;
  logic [AREA_W-1:0]  mag;
  logic [SUM_W-1:0]   total;
  logic               hit_bit;
  logic               last_tri;

  assign cur = slot_rd[tri_cnt];

  // Feed the area unit: phase 0 the triangle itself, phases 1-3 replace
  // vertex A, B, C respectively by the query point.
  always_comb begin
    u_ax = cur.ax;
    u_ay = cur.ay;
    u_bx = cur.bx;
    u_by = cur.by;
    u_cx = cur.cx;
    u_cy = cur.cy;
    case (phase)
      2'd1: begin
        u_ax = px;
        u_ay = py;
      end
      2'd2: begin
        u_bx = px;
        u_by = py;
      end
      2'd3: begin
        u_cx = px;
        u_cy = py;
      end
      default: ;
    endcase
  end

  tri_area2 #(
    .COORD_W (COORD_W),
    .AREA_W  (AREA_W)
  ) u_area (
    .ax   (u_ax),
    .ay   (u_ay),
    .bx   (u_bx),
    .by   (u_by),
    .cx   (u_cx),
    .cy   (u_cy),
    .area (area)
  );

  // Magnitude cannot hit the most negative code, so negation is exact.
  assign mag      = area[AREA_W-1] ? $unsigned(-area) : $unsigned(area);
  assign total    = sum + SUM_W'(mag);
  assign last_tri = (tri_cnt == 4'(NTRI - 1));

`ifdef TRI_HIT_DEGEN_REJECT_EN
  assign hit_bit = (a0_mag != '0) && (SUM_W'(a0_mag) == total);
`else
  assign hit_bit = (SUM_W'(a0_mag) == total);
`endif

  // Sequencer: accept a point, walk every triangle through four phases,
  // then hold the result until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      phase     <= 2'd0;
      tri_cnt   <= 4'd0;
      px        <= '0;
      py        <= '0;
      a0_mag    <= '0;
      sum       <= '0;
      hit_mask  <= '0;
      hit_any   <= 1'b0;
      q_ready   <= 1'b1;
      res_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (q_valid && q_ready) begin
            px       <= q_px;
            py       <= q_py;
            phase    <= 2'd0;
            tri_cnt  <= 4'd0;
            hit_mask <= '0;
            hit_any  <= 1'b0;
            q_ready  <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          phase <= phase + 2'd1;
          case (phase)
            2'd0: a0_mag <= mag;
            2'd1: sum    <= SUM_W'(mag);
            2'd2: sum    <= total;
            default: begin
              hit_mask <= hit_mask | (tri_sel & {NTRI{hit_bit}});
              hit_any  <= hit_any | hit_bit;
              if (last_tri) begin
                tri_cnt   <= 4'd0;
                res_valid <= 1'b1;
                state     <= DONE;
              end else begin
                tri_cnt <= tri_cnt + 4'd1;
              end
            end
          endcase
        end
        DONE: begin
          if (res_valid && res_ready) begin
            res_valid <= 1'b0;
            q_ready   <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          res_valid <= 1'b0;
          q_ready   <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tri_hit_seq.sv
// Randomized bench for tri_hit_seq with a behavioural point-in-triangle
// reference model. Honours TRI_HIT_DEGEN_REJECT_EN the same way the design does.
module tb_tri_hit_seq;

  localparam int COORD_W = 10;
  localparam int NTRI    = 4;
  localparam int CMAX    = (1 << COORD_W) - 1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               tri_we = 1'b0;
  logic [3:0]         tri_idx = '0;
  logic [COORD_W-1:0] tri_ax = '0, tri_ay = '0, tri_bx = '0;
  logic [COORD_W-1:0] tri_by = '0, tri_cx = '0, tri_cy = '0;
  logic               q_valid = 1'b0;
  logic               q_ready;
  logic [COORD_W-1:0] q_px = '0, q_py = '0;
  logic               res_valid;
  logic               res_ready = 1'b0;
  logic [NTRI-1:0]    hit_mask;
  logic               hit_any;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference triangle store: vertex coordinates per slot
  int m_tri [NTRI][6];

  tri_hit_seq #(
    .COORD_W (COORD_W),
    .NTRI    (NTRI)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tri_we    (tri_we),
    .tri_idx   (tri_idx),
    .tri_ax    (tri_ax),
    .tri_ay    (tri_ay),
    .tri_bx    (tri_bx),
    .tri_by    (tri_by),
    .tri_cx    (tri_cx),
    .tri_cy    (tri_cy),
    .q_valid   (q_valid),
    .q_ready   (q_ready),
    .q_px      (q_px),
    .q_py      (q_py),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .hit_mask  (hit_mask),
    .hit_any   (hit_any)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint dbl_area(input longint ax, input longint ay,
                                      input longint bx, input longint by,
                                      input longint cx, input longint cy);
    longint a;
    a = ax * (by - cy) + bx * (cy - ay) + cx * (ay - by);
    return (a < 0) ? -a : a;
  endfunction

  // Inside-or-on test by area decomposition
  function automatic bit model_hit(input int t, input int px, input int py);
    longint a0, a1, a2, a3;
    bit h;
    a0 = dbl_area(m_tri[t][0], m_tri[t][1], m_tri[t][2], m_tri[t][3], m_tri[t][4], m_tri[t][5]);
    a1 = dbl_area(px, py, m_tri[t][2], m_tri[t][3], m_tri[t][4], m_tri[t][5]);
    a2 = dbl_area(m_tri[t][0], m_tri[t][1], px, py, m_tri[t][4], m_tri[t][5]);
    a3 = dbl_area(m_tri[t][0], m_tri[t][1], m_tri[t][2], m_tri[t][3], px, py);
    h = (a0 == a1 + a2 + a3);
`ifdef TRI_HIT_DEGEN_REJECT_EN
    if (a0 == 0) h = 1'b0;
`endif
    return h;
  endfunction

  function automatic logic [NTRI-1:0] model_mask(input int px, input int py);
    logic [NTRI-1:0] m;
    m = '0;
    for (int t = 0; t < NTRI; t++) m[t] = model_hit(t, px, py);
    return m;
  endfunction

  task automatic model_clear();
    for (int t = 0; t < NTRI; t++)
      for (int k = 0; k < 6; k++) m_tri[t][k] = 0;
  endtask

  // Write one triangle while idle (called #1 after a rising edge)
  task automatic write_tri(input int idx, input int ax, input int ay, input int bx,
                           input int by, input int cx, input int cy);
    tri_we  = 1'b1;
    tri_idx = 4'(idx);
    tri_ax  = COORD_W'(ax);
    tri_ay  = COORD_W'(ay);
    tri_bx  = COORD_W'(bx);
    tri_by  = COORD_W'(by);
    tri_cx  = COORD_W'(cx);
    tri_cy  = COORD_W'(cy);
    @(posedge clk);
    #1;
    tri_we = 1'b0;
    if (idx < NTRI) begin
      m_tri[idx][0] = ax; m_tri[idx][1] = ay; m_tri[idx][2] = bx;
      m_tri[idx][3] = by; m_tri[idx][4] = cx; m_tri[idx][5] = cy;
    end
    $display("write   idx=%0d (%0d,%0d) (%0d,%0d) (%0d,%0d)", idx, ax, ay, bx, by, cx, cy);
  endtask

  task automatic rand_tri(input int idx);
    write_tri(idx, $urandom_range(0, CMAX), $urandom_range(0, CMAX), $urandom_range(0, CMAX),
              $urandom_range(0, CMAX), $urandom_range(0, CMAX), $urandom_range(0, CMAX));
  endtask

  // One full query. want_idx >= 0 additionally checks that bit against a
  // hand-derived value. poke writes a triangle during CALC; abort resets mid-CALC.
  task automatic do_query(input int px, input int py, input int want_idx, input int want_val,
                          input bit poke, input bit abort);
    logic [NTRI-1:0] exp_mask;
    logic [NTRI-1:0] held_mask;
    int guard;
    int lat;
    int hold;
    bit rdy;

    exp_mask = model_mask(px, py);
    q_px    = COORD_W'(px);
    q_py    = COORD_W'(py);
    q_valid = 1'b1;
    guard   = 0;
    do begin
      rdy = q_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!rdy && guard < 50);
    q_valid = 1'b0;
    q_px    = '0;
    q_py    = '0;
    if (!rdy) begin
      check("accept_timeout", 0, 1);
      return;
    end
    check("q_ready_busy", q_ready, 0);

    lat = 0;
    while (!res_valid && lat < 200) begin
      tri_we = 1'b0;
      if (lat == 4) begin
        check("partial_bit0", hit_mask[0], exp_mask[0]);
        check("partial_hi", hit_mask[NTRI-1:1], 0);
      end
      if (poke && lat == 5) begin
        tri_we  = 1'b1;
        tri_idx = 4'($urandom_range(0, NTRI - 1));
        tri_ax  = COORD_W'($urandom);
        tri_ay  = COORD_W'($urandom);
        tri_bx  = COORD_W'($urandom);
        tri_by  = COORD_W'($urandom);
        tri_cx  = COORD_W'($urandom);
        tri_cy  = COORD_W'($urandom);
      end
      if (abort && lat == 7) begin
        rst_n = 1'b0;
        #2;
        check("abort_res_valid", res_valid, 0);
        check("abort_hit_mask", hit_mask, 0);
        check("abort_hit_any", hit_any, 0);
        model_clear();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("abort_q_ready", q_ready, 1);
        $display("query   p=(%0d,%0d) aborted by reset", px, py);
        return;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    tri_we = 1'b0;

    check("latency", lat, 4 * NTRI);
    check("hit_mask", hit_mask, exp_mask);
    check("hit_any", hit_any, |exp_mask);
    if (want_idx >= 0) check("directed_bit", hit_mask[want_idx], want_val);

    held_mask = hit_mask;
    hold = $urandom_range(0, 5);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", res_valid, 1);
      check("hold_mask", hit_mask, held_mask);
      check("hold_q_ready", q_ready, 0);
    end

    // Release with a new offer present: it must not be taken on this edge
    res_ready = 1'b1;
    q_valid   = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    q_valid   = 1'b0;
    check("release_valid", res_valid, 0);
    check("release_q_ready", q_ready, 1);
    $display("query   p=(%0d,%0d) lat=%0d mask=%b exp=%b hold=%0d", px, py, lat, hit_mask,
             exp_mask, hold);
  endtask

  initial begin
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_res_valid", res_valid, 0);
    check("rst_hit_mask", hit_mask, 0);
    check("rst_hit_any", hit_any, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_q_ready", q_ready, 1);

    // Directed geometry
    write_tri(0, 0, 0, 10, 0, 0, 10);
    write_tri(1, 0, 0, CMAX, 0, 0, CMAX);
    write_tri(2, 0, 0, 5, 5, 10, 10);
    write_tri(3, 100, 100, 200, 100, 100, 200);
    write_tri(9, 1, 2, 3, 4, 5, 6);          // out of range, must be dropped
    do_query(2, 2, 0, 1, 1'b0, 1'b0);
    do_query(8, 8, 0, 0, 1'b1, 1'b0);        // also writes during CALC
    do_query(5, 5, 0, 1, 1'b0, 1'b0);
    do_query(0, 0, 0, 1, 1'b0, 1'b0);
    do_query(CMAX, CMAX, 1, 0, 1'b0, 1'b0);
    do_query(511, 511, 1, 1, 1'b0, 1'b0);
`ifdef TRI_HIT_DEGEN_REJECT_EN
    do_query(3, 3, 2, 0, 1'b0, 1'b0);
`else
    do_query(3, 3, 2, 1, 1'b0, 1'b0);
`endif

    // Abort mid-CALC, then rebuild and re-query
    do_query(2, 2, -1, 0, 1'b0, 1'b1);
    write_tri(0, 0, 0, 10, 0, 0, 10);
    do_query(2, 2, 0, 1, 1'b0, 1'b0);

    // Randomized triangles and points
    for (int n = 0; n < 24; n++) begin
      int t;
      int px;
      int py;
      if (n % 4 == 0) begin
        for (int k = 0; k < NTRI; k++) rand_tri(k);
      end
      t = $urandom_range(0, NTRI - 1);
      if ($urandom_range(0, 1) == 1) begin
        px = (m_tri[t][0] + m_tri[t][2] + m_tri[t][4]) / 3;
        py = (m_tri[t][1] + m_tri[t][3] + m_tri[t][5]) / 3;
      end else begin
        px = $urandom_range(0, CMAX);
        py = $urandom_range(0, CMAX);
      end
      do_query(px, py, -1, 0, ($urandom_range(0, 3) == 0), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
